// File: rtl/dec_iter.sv
// Iterative AES-128 decryption core, one inverse round per clock.
// Round keys are written by encryption round number (0..10), so the same
// key-schedule loader can feed both this block and the encryptor.
// Byte k of a block is bits [127-8k -: 8], column-major (row = k%4, col = k/4).

// Inverse S-box byte lookup (combinational).
module inv_sbox (
  input  logic [7:0] i_x,
  output logic [7:0] o_y
);
  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_y = INV_SBOX[i_x];
endmodule

module dec_iter #(
  parameter int NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [127:0] i_rkey,
  input  logic [3:0]   i_addr,
  input  logic         i_rkey_we,
  input  logic [127:0] i_din,
  input  logic         i_din_valid,
  output logic         o_din_ready,
  output logic [127:0] o_dout,
  output logic         o_dout_valid,
  input  logic         i_dout_ready
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_t;

  fsm_t         r_fsm;
  fsm_t         w_fsm_next;
  logic [127:0] r_blk;
  logic [127:0] w_blk_next;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_next;
  logic [127:0] r_rk [0:NR];

  logic [127:0] w_isr;     // after InvShiftRows
  logic [127:0] w_isb;     // after InvSubBytes
  logic [127:0] w_t;       // after AddRoundKey
  logic [127:0] w_imc;     // after InvMixColumns
  logic [127:0] w_rk_cur;

  // Multiply by x in GF(2^8) modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column: matrix rows {0e 0b 0d 09} rotated.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows rotates row r right by r, then each byte goes through inv_sbox.
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign w_isr[127-8*gi -: 8] = r_blk[127-8*SRC -: 8];
    inv_sbox u_inv_sbox (
      .i_x (w_isr[127-8*gi -: 8]),
      .o_y (w_isb[127-8*gi -: 8])
    );
  end

  assign w_rk_cur = r_rk[r_cnt];
  assign w_t      = w_isb ^ w_rk_cur;

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign w_imc[127-32*gi -: 32] = inv_mix_col(w_t[127-32*gi -: 32]);
  end

  // Key store: writes only land while idle and only for indices 0..NR.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= NR; i++) r_rk[i] <= '0;
    end else if (i_rkey_we && (r_fsm == S_IDLE) && (i_addr <= 4'(NR))) begin
      r_rk[i_addr] <= i_rkey;
    end
  end

  // State register for FSM, round counter and data block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm <= S_IDLE;
      r_blk <= '0;
      r_cnt <= '0;
    end else begin
      r_fsm <= w_fsm_next;
      r_blk <= w_blk_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Next-state logic: load with rk[NR] whitening, then NR inverse rounds.
  always_comb begin
    w_fsm_next = r_fsm;
    w_blk_next = r_blk;
    w_cnt_next = r_cnt;
    case (r_fsm)
      S_IDLE: begin
        if (i_din_valid) begin
          w_blk_next = i_din ^ r_rk[NR];
          w_cnt_next = 4'(NR - 1);
          w_fsm_next = S_ROUND;
        end
      end
      S_ROUND: begin
        if (r_cnt != 4'd0) begin
          w_blk_next = w_imc;
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_blk_next = w_t;
          w_fsm_next = S_DONE;
        end
      end
      S_DONE: begin
        if (i_dout_ready) w_fsm_next = S_IDLE;
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  assign o_din_ready  = (r_fsm == S_IDLE);
  assign o_dout_valid = (r_fsm == S_DONE);
  assign o_dout       = r_blk;

endmodule

// File: tb/tb_dec_iter.sv
// Bench for dec_iter: a reference AES-128 encryptor (S-box derived from the
// GF(2^8) inverse plus affine map) produces ciphertexts; expected plaintexts
// are queued at acceptance and compared when the core delivers output.
module tb_dec_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] rkey;
  logic [3:0]   addr;
  logic         rkey_we;
  logic [127:0] din;
  logic         din_valid;
  logic         din_ready;
  logic [127:0] dout;
  logic         dout_valid;
  logic         dout_ready;

  always #5 clk = ~clk;

  dec_iter #(.NR(10)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rkey       (rkey),
    .i_addr       (addr),
    .i_rkey_we    (rkey_we),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .o_din_ready  (din_ready),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .i_dout_ready (dout_ready)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [127:0] exp_q [$];
  logic [7:0]   sb [0:255];
  logic [127:0] m_rk [0:10];
  logic [127:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] v;
    v = pt ^ m_rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int k = 0; k < 16; k++) s[k] = v[127-8*k -: 8];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = sb[s[4*((c+row)%4)+row]];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end else begin
        for (int k = 0; k < 16; k++) s[k] = t[k];
      end
      for (int k = 0; k < 16; k++) v[127-8*k -: 8] = s[k];
      v = v ^ m_rk[r];
    end
    return v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out act=%h exp=none", dout);
      end else begin
        mon_e = exp_q.pop_front();
        $display("out dout=%h exp=%h", dout, mon_e);
        chk("dout", dout, mon_e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_keys();
    for (int i = 0; i < 11; i++) begin
      rkey = m_rk[i]; addr = 4'(i); rkey_we = 1'b1;
      @(posedge clk); #1;
    end
    rkey_we = 1'b0;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
    int n = 0;
    din = ct; din_valid = 1'b1;
    while (din_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL accept_timeout act=%0d exp=<100", n);
    end
    exp_q.push_back(pt);
    @(posedge clk);
    #1;
    acc = cyc;
    din_valid = 1'b0;
    $display("in  din=%h acc_cyc=%0d", ct, acc);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (dout_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout act=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- main test ----------------
  vec_t vecs [2];
  int   acc, prev, n;
  logic [127:0] p, c, hold;

  initial begin
    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};

    rst_n = 1'b0; rkey = '0; addr = '0; rkey_we = 1'b0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    build_sbox();
    #12;
    chk("rst_dout_valid", 128'(dout_valid), 128'd0);
    chk("rst_dout", dout, 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_din_ready", 128'(din_ready), 128'd1);

    // Known-answer vectors with latency check.
    for (int i = 0; i < 2; i++) begin
      expand(vecs[i].key);
      load_keys();
      send(vecs[i].ct, vecs[i].pt, acc);
      wait_valid(n);
      chk("latency", 128'(n), 128'd10);
      wait_drain();
    end

    // Backpressure: output held, no second acceptance.
    expand(vecs[0].key);
    load_keys();
    dout_ready = 1'b0;
    send(vecs[0].ct, vecs[0].pt, acc);
    wait_valid(n);
    chk("bp_latency", 128'(n), 128'd10);
    hold = dout;
    din = vecs[1].ct; din_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("bp_dout_stable", dout, vecs[0].pt);
      chk("bp_din_ready", 128'(din_ready), 128'd0);
      chk("bp_dout_valid", 128'(dout_valid), 128'd1);
    end
    chk("bp_hold", hold, vecs[0].pt);
    din_valid = 1'b0;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_ready", 128'(din_ready), 128'd1);
    chk("bp_valid_drop", 128'(dout_valid), 128'd0);
    repeat (15) @(posedge clk);
    #1;
    chk("bp_no_second", 128'(dout_valid), 128'd0);
    chk("bp_queue_empty", 128'(exp_q.size()), 128'd0);

    // Key write during ROUND is dropped.
    send(vecs[0].ct, vecs[0].pt, acc);
    repeat (3) @(posedge clk);
    #1;
    rkey = '1; addr = 4'd10; rkey_we = 1'b1;
    @(posedge clk); #1;
    rkey_we = 1'b0;
    wait_drain();
    send(vecs[0].ct, vecs[0].pt, acc);
    wait_drain();
    // Out-of-range index in IDLE is ignored.
    rkey = '1; addr = 4'd12; rkey_we = 1'b1;
    @(posedge clk); #1;
    rkey_we = 1'b0;
    send(vecs[0].ct, vecs[0].pt, acc);
    wait_drain();

    // Same-edge key write and acceptance: load uses old rk[10], write commits.
    din = vecs[0].ct; din_valid = 1'b1;
    rkey = '1; addr = 4'd10; rkey_we = 1'b1;
    exp_q.push_back(vecs[0].pt);
    @(posedge clk); #1;
    din_valid = 1'b0; rkey_we = 1'b0;
    wait_drain();
    m_rk[10] = '1;
    p = {$urandom, $urandom, $urandom, $urandom};
    c = aes_enc(p);
    send(c, p, acc);
    wait_drain();
    expand(vecs[0].key);
    load_keys();

    // Asynchronous reset mid-round.
    send(vecs[0].ct, vecs[0].pt, acc);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(dout_valid), 128'd0);
    chk("mid_rst_ready", 128'(din_ready), 128'd1);
    chk("mid_rst_dout", dout, 128'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 128'(din_ready), 128'd1);
    chk("post_rst_valid", 128'(dout_valid), 128'd0);
    for (int i = 0; i < 11; i++) m_rk[i] = '0;
    p = {$urandom, $urandom, $urandom, $urandom};
    c = aes_enc(p);
    send(c, p, acc);
    wait_drain();
    expand(vecs[0].key);
    load_keys();
    send(vecs[0].ct, vecs[0].pt, acc);
    wait_drain();

    // Back-to-back stream with a random key.
    expand({$urandom, $urandom, $urandom, $urandom});
    load_keys();
    prev = 0;
    for (int b = 0; b < 8; b++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      c = aes_enc(p);
      send(c, p, acc);
      if (b > 0) chk("b2b_spacing", 128'(acc - prev), 128'd12);
      prev = acc;
    end
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_iter.md
Name: dec_iter

Overview:
- Iterative AES-128 decryption core: the inverse of the unrolled encryption pipeline. Recovers plaintext from ciphertext one round per clock.
- Round keys are loaded through the same rkey/addr write interface and indexing as the encryptor, so one shared key-schedule loader drives both blocks.
- Block-level valid/ready handshakes on input and output. One block in flight at a time.
- Uses the existing combinational inv_sbox byte-lookup module (16 instances). InvShiftRows, InvMixColumns and AddRoundKey are local logic.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported; sets key-store depth to NR+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rkey  in  128  round key write data
- addr  in  4  round key write index, encryption round number 0..10
- rkey_we  in  1  round key write strobe
- din  in  128  ciphertext block; byte0 = din[127:120], column-major per FIPS-197
- din_valid  in  1  din is valid
- din_ready  out  1  core can accept a block
- dout  out  128  plaintext block, same byte order as din
- dout_valid  out  1  dout is valid
- dout_ready  in  1  consumer accepts dout

Behaviour:
- Key store: 11 x 128-bit registers rk[0..10].
  - rk[addr] <= rkey on a clk edge with rkey_we=1, addr<=10, FSM in IDLE.
  - addr 11..15 is ignored. Writes in ROUND or DONE are dropped.
  - rk[10] is the last encryption key and is applied first on decrypt.
- FSM states: IDLE, ROUND, DONE. Reset state is IDLE.
- IDLE:
  - din_ready=1.
  - On din_valid & din_ready: state <= din ^ rk[10], cnt <= 9, go to ROUND.
- ROUND, each cycle:
  - t = InvSubBytes(InvShiftRows(state)) ^ rk[cnt].
  - cnt != 0: state <= InvMixColumns(t), cnt <= cnt-1.
  - cnt == 0: state <= t, go to DONE.
- DONE:
  - dout_valid=1, dout = state, held stable until accepted.
  - On dout_ready: go to IDLE. dout_valid drops the next cycle.
- din_ready=1 only in IDLE. dout_valid=1 only in DONE. din is ignored outside IDLE.
- Latency: acceptance edge T0; dout_valid rises after edge T10 (10 cycles).
  - Minimum occupancy: 12 cycles per block with dout_ready held high (T0, ten ROUND edges, DONE-to-IDLE edge).
- dout is driven from the state register and changes only in ROUND/T0 loads. It may show intermediate values while dout_valid=0.
- Simultaneous rkey_we and din acceptance in IDLE, same edge:
  - The key write commits.
  - The T0 load uses the pre-write rk[10].
- Reset (rst=0), asynchronous, any time including mid-round:
  - FSM to IDLE, cnt=0, state=0, all rk=0.
  - din_ready=1 once rst is high. dout_valid=0, dout=0.
  - The in-flight block is discarded.
- Arithmetic:
  - InvMixColumns uses GF(2^8) with polynomial 0x11B and coefficients 0e,0b,0d,09.
  - xtime is implemented as shift plus conditional XOR 0x1B. No multipliers.
- cnt is 4 bits. Values 10..15 are unreachable in ROUND.

Test Plan:
- FIPS-197 C.1: load rk[0..10] from key 000102030405060708090a0b0c0d0e0f (rk0=000102030405060708090a0b0c0d0e0f, rk10=13111d7fe3944a17f307a78b4d2b30c5). Send din=69c4e0d86a7b0430d8cdb78070b4c55a → dout=00112233445566778899aabbccddeeff, dout_valid exactly 10 cycles after acceptance.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c (rk10=d014f9a8c9ee2589e13f0cc8b6630ca6). Send din=3925841d02dc09fbdc118597196a0b32 → dout=3243f6a8885a308d313198a2e0370734.
- Backpressure: hold dout_ready=0 for 20 cycles after dout_valid → dout stable, din_ready=0 throughout, second din_valid not accepted. Release dout_ready → IDLE next cycle.
- Key write blocking: during ROUND write addr=10 with rkey=all-ones → ignored; current and next decrypt of the C.1 vector still correct. Write addr=12 in IDLE → no rk change.
- Reset mid-operation: assert rst=0 at cycle 5 of ROUND → dout_valid=0, din_ready=1 after release, all keys zero. Reload keys, rerun C.1 → correct result.
- Back-to-back: stream encryptor outputs for 8 random blocks with dout_ready=1 → each decrypts to its original plaintext, 12-cycle accept spacing.
